// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I sequencing controller:
// states, opcodes, datapath select codes and fault causes.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JAL_LINK = 4'd12,
        S_UTYPE    = 4'd13,
        S_FAULT    = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_IMM    = 2'b01;
    localparam logic [1:0] SRC_B_FOUR   = 2'b10;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_CMP   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALU_OUT  = 2'b00;
    localparam logic [1:0] RES_MEM_DATA = 2'b01;
    localparam logic [1:0] RES_ALU_RES  = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface multicycle_ctrl_fsm_if #(
    parameter int unsigned RETIRE_CNT_W = 32
);
    logic [6:0]              opcode_i;
    logic                    mem_ready_i;
    logic                    pc_wr_en_o;
    logic                    ir_wr_en_o;
    logic                    adr_src_o;
    logic                    mem_req_o;
    logic                    mem_wr_en_o;
    logic                    reg_wr_en_o;
    logic [1:0]              alu_src_a_o;
    logic [1:0]              alu_src_b_o;
    logic [1:0]              alu_op_o;
    logic [1:0]              result_src_o;
    logic                    branch_o;
    logic                    retire_o;
    logic [RETIRE_CNT_W-1:0] retire_cnt_o;
    logic                    fault_o;
    logic [1:0]              fault_cause_o;
    logic [3:0]              state_o;

    modport master (
        input  opcode_i, mem_ready_i,
        output pc_wr_en_o, ir_wr_en_o, adr_src_o, mem_req_o, mem_wr_en_o,
               reg_wr_en_o, alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o,
               branch_o, retire_o, retire_cnt_o, fault_o, fault_cause_o, state_o
    );

    modport slave (
        output opcode_i, mem_ready_i,
        input  pc_wr_en_o, ir_wr_en_o, adr_src_o, mem_req_o, mem_wr_en_o,
               reg_wr_en_o, alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o,
               branch_o, retire_o, retire_cnt_o, fault_o, fault_cause_o, state_o
    );
endinterface

// File: rtl/mem_timeout_cnt.sv
// Counts consecutive cycles a memory request waits; flags the LIMIT-th wait.
module mem_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic cnt_en,
    output logic expired
);
    localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt_en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires during the wait cycle that would bring the count up to LIMIT;
    // a ready in that same cycle deasserts cnt_en and so takes precedence.
    always_comb begin
        expired = (LIMIT != 0) && cnt_en && (cnt == W'(LIMIT - 1));
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I sequencing FSM: per-state datapath enables/selects,
// memory handshake with timeout, illegal-opcode fault and retire counting.
module multicycle_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned RETIRE_CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_ctrl_fsm_if.master bus
);
    state_t                  state, next_state;
    logic [1:0]              fault_cause, next_cause;
    logic [RETIRE_CNT_W-1:0] retire_cnt;
    logic                    tmo_expired;
    logic                    ready;

    logic       pc_wr, ir_wr, adr, req, wr, reg_wr, branch, retire, fault;
    logic [1:0] src_a, src_b, aop, res;

    assign ready = bus.mem_ready_i;

    mem_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!req || ready),
        .cnt_en  (req && !ready),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            fault_cause <= CAUSE_NONE;
            retire_cnt  <= '0;
        end else begin
            state       <= next_state;
            fault_cause <= next_cause;
            if (retire) retire_cnt <= retire_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        next_cause = fault_cause;
        pc_wr = 1'b0; ir_wr = 1'b0; adr = 1'b0; req = 1'b0; wr = 1'b0;
        reg_wr = 1'b0; branch = 1'b0; retire = 1'b0; fault = 1'b0;
        src_a = SRC_A_PC; src_b = SRC_B_RS2; aop = ALU_OP_ADD; res = RES_ALU_OUT;
        // Outputs are forced idle while reset is held so an in-flight request drops at once.
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    req = 1'b1; src_b = SRC_B_FOUR; res = RES_ALU_RES;
                    if (ready) begin
                        ir_wr = 1'b1; pc_wr = 1'b1; next_state = S_DECODE;
                    end else if (tmo_expired) begin
                        next_state = S_FAULT; next_cause = CAUSE_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    src_a = SRC_A_OLD_PC; src_b = SRC_B_IMM;
                    case (bus.opcode_i)
                        OP_LOAD, OP_STORE: next_state = S_MEM_ADDR;
                        OP_R:              next_state = S_EXEC_R;
                        OP_I:              next_state = S_EXEC_I;
                        OP_BRANCH:         next_state = S_BRANCH;
                        OP_JAL:            next_state = S_JAL;
                        OP_JALR:           next_state = S_JALR;
                        OP_LUI, OP_AUIPC:  next_state = S_UTYPE;
                        default: begin
                            next_state = S_FAULT; next_cause = CAUSE_ILLEGAL;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    src_a = SRC_A_RS1; src_b = SRC_B_IMM;
                    next_state = (bus.opcode_i == OP_STORE) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    req = 1'b1; adr = 1'b1;
                    if (ready) begin
                        next_state = S_MEM_WB;
                    end else if (tmo_expired) begin
                        next_state = S_FAULT; next_cause = CAUSE_TIMEOUT;
                    end
                end
                S_MEM_WB: begin
                    res = RES_MEM_DATA; reg_wr = 1'b1; retire = 1'b1; next_state = S_FETCH;
                end
                S_MEM_WR: begin
                    req = 1'b1; wr = 1'b1; adr = 1'b1;
                    if (ready) begin
                        retire = 1'b1; next_state = S_FETCH;
                    end else if (tmo_expired) begin
                        next_state = S_FAULT; next_cause = CAUSE_TIMEOUT;
                    end
                end
                S_EXEC_R: begin
                    src_a = SRC_A_RS1; src_b = SRC_B_RS2; aop = ALU_OP_FUNCT; next_state = S_ALU_WB;
                end
                S_EXEC_I: begin
                    src_a = SRC_A_RS1; src_b = SRC_B_IMM; aop = ALU_OP_FUNCT; next_state = S_ALU_WB;
                end
                S_ALU_WB: begin
                    res = RES_ALU_OUT; reg_wr = 1'b1; retire = 1'b1; next_state = S_FETCH;
                end
                S_BRANCH: begin
                    src_a = SRC_A_RS1; src_b = SRC_B_RS2; aop = ALU_OP_CMP; res = RES_ALU_OUT;
                    branch = 1'b1; retire = 1'b1; next_state = S_FETCH;
                end
                S_JAL: begin
                    src_a = SRC_A_OLD_PC; src_b = SRC_B_FOUR; res = RES_ALU_OUT;
                    pc_wr = 1'b1; next_state = S_ALU_WB;
                end
                S_JALR: begin
                    src_a = SRC_A_RS1; src_b = SRC_B_IMM; res = RES_ALU_RES;
                    pc_wr = 1'b1; next_state = S_JAL_LINK;
                end
                S_JAL_LINK: begin
                    src_a = SRC_A_OLD_PC; src_b = SRC_B_FOUR; next_state = S_ALU_WB;
                end
                S_UTYPE: begin
                    src_a = (bus.opcode_i == OP_LUI) ? SRC_A_ZERO : SRC_A_OLD_PC;
                    src_b = SRC_B_IMM; next_state = S_ALU_WB;
                end
                S_FAULT: fault = 1'b1;
                default: next_state = S_FETCH;
            endcase
        end
    end

    assign bus.pc_wr_en_o    = pc_wr;
    assign bus.ir_wr_en_o    = ir_wr;
    assign bus.adr_src_o     = adr;
    assign bus.mem_req_o     = req;
    assign bus.mem_wr_en_o   = wr;
    assign bus.reg_wr_en_o   = reg_wr;
    assign bus.alu_src_a_o   = src_a;
    assign bus.alu_src_b_o   = src_b;
    assign bus.alu_op_o      = aop;
    assign bus.result_src_o  = res;
    assign bus.branch_o      = branch;
    assign bus.retire_o      = retire;
    assign bus.retire_cnt_o  = retire_cnt;
    assign bus.fault_o       = fault;
    assign bus.fault_cause_o = fault_cause;
    assign bus.state_o       = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: instruction-level phase model compared every
// cycle, plus literal checks of retire count, fault cause and async reset.
module tb_multicycle_ctrl_fsm;
    import cpu_ctrl_pkg::*;

    localparam int unsigned TMO = 4;
    localparam int unsigned CW  = 4;

    typedef struct packed {
        logic       pc_wr, ir_wr, adr, req, wr, reg_wr;
        logic [1:0] sa, sb, op, res;
        logic       branch, retire, fault;
        logic [1:0] cause;
        logic [3:0] st;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    multicycle_ctrl_fsm_if #(.RETIRE_CNT_W(CW)) bus ();

    multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(TMO), .RETIRE_CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        exp_v;
    logic        exp_valid = 1'b0;
    logic [1:0]  m_cause = 2'b00;
    logic [CW-1:0] m_cnt = '0;
    state_t      seq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    // Expected outputs of one instruction phase, straight from the output table.
    function automatic exp_t row(input state_t ph, input logic rdy, input logic [6:0] opc);
        exp_t e = '0;
        e.st = ph;
        case (ph)
            S_FETCH:    begin e.req = 1; e.sb = 2'b10; e.res = 2'b10; e.pc_wr = rdy; e.ir_wr = rdy; end
            S_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; end
            S_MEM_ADDR: begin e.sa = 2'b10; e.sb = 2'b01; end
            S_MEM_RD:   begin e.req = 1; e.adr = 1; end
            S_MEM_WB:   begin e.res = 2'b01; e.reg_wr = 1; e.retire = 1; end
            S_MEM_WR:   begin e.req = 1; e.wr = 1; e.adr = 1; e.retire = rdy; end
            S_EXEC_R:   begin e.sa = 2'b10; e.op = 2'b10; end
            S_EXEC_I:   begin e.sa = 2'b10; e.sb = 2'b01; e.op = 2'b10; end
            S_ALU_WB:   begin e.reg_wr = 1; e.retire = 1; end
            S_BRANCH:   begin e.sa = 2'b10; e.op = 2'b01; e.branch = 1; e.retire = 1; end
            S_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; e.pc_wr = 1; end
            S_JALR:     begin e.sa = 2'b10; e.sb = 2'b01; e.res = 2'b10; e.pc_wr = 1; end
            S_JAL_LINK: begin e.sa = 2'b01; e.sb = 2'b10; end
            S_UTYPE:    begin e.sa = (opc == 7'b0110111) ? 2'b11 : 2'b01; e.sb = 2'b01; end
            S_FAULT:    e.fault = 1;
            default:    e.st = ph;
        endcase
        return e;
    endfunction

    task automatic build_seq(input logic [6:0] opc);
        seq.delete();
        seq.push_back(S_FETCH);
        seq.push_back(S_DECODE);
        case (opc)
            7'b0000011: begin seq.push_back(S_MEM_ADDR); seq.push_back(S_MEM_RD); seq.push_back(S_MEM_WB); end
            7'b0100011: begin seq.push_back(S_MEM_ADDR); seq.push_back(S_MEM_WR); end
            7'b0110011: begin seq.push_back(S_EXEC_R); seq.push_back(S_ALU_WB); end
            7'b0010011: begin seq.push_back(S_EXEC_I); seq.push_back(S_ALU_WB); end
            7'b1100011: seq.push_back(S_BRANCH);
            7'b1101111: begin seq.push_back(S_JAL); seq.push_back(S_ALU_WB); end
            7'b1100111: begin seq.push_back(S_JALR); seq.push_back(S_JAL_LINK); seq.push_back(S_ALU_WB); end
            7'b0110111, 7'b0010111: begin seq.push_back(S_UTYPE); seq.push_back(S_ALU_WB); end
            default:    seq.push_back(S_FAULT);
        endcase
    endtask

    // Called at posedge+1: drive one cycle, publish expectations, advance to next posedge+1.
    task automatic step(input state_t ph, input logic rdy);
        bus.mem_ready_i = rdy;
        exp_v = row(ph, rdy, bus.opcode_i);
        exp_v.cause = m_cause;
        exp_valid = 1'b1;
        @(posedge clk);
        if (exp_v.retire) m_cnt = m_cnt + 1'b1;
        #1;
    endtask

    task automatic hold_fault(input int unsigned n, input logic noise);
        for (int unsigned i = 0; i < n; i++) step(S_FAULT, noise ^ i[0]);
    endtask

    task automatic run_instr(input logic [6:0] opc, input int unsigned flat, input int unsigned mlat,
                             input logic noise, input int unsigned hold);
        int unsigned lat;
        bit          timed_out;
        bus.opcode_i = opc;
        build_seq(opc);
        foreach (seq[i]) begin
            if (seq[i] == S_FETCH || seq[i] == S_MEM_RD || seq[i] == S_MEM_WR) begin
                lat = (seq[i] == S_FETCH) ? flat : mlat;
                timed_out = 1'b0;
                for (int unsigned w = 0; w <= lat; w++) begin
                    if (w == lat) begin
                        step(seq[i], 1'b1);
                        break;
                    end
                    step(seq[i], 1'b0);
                    if (w + 1 == TMO) begin
                        timed_out = 1'b1;
                        break;
                    end
                end
                if (timed_out) begin
                    m_cause = 2'b10;
                    hold_fault(hold, noise);
                    return;
                end
            end else if (seq[i] == S_FAULT) begin
                m_cause = 2'b01;
                hold_fault(hold, noise);
                return;
            end else begin
                step(seq[i], noise);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.mem_ready_i = 1'b1;
        m_cause = 2'b00;
        m_cnt = '0;
        exp_v = '0;
        exp_v.st = S_FETCH;
        exp_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("pc_wr_en",    32'(bus.pc_wr_en_o),    32'(exp_v.pc_wr));
            chk("ir_wr_en",    32'(bus.ir_wr_en_o),    32'(exp_v.ir_wr));
            chk("adr_src",     32'(bus.adr_src_o),     32'(exp_v.adr));
            chk("mem_req",     32'(bus.mem_req_o),     32'(exp_v.req));
            chk("mem_wr_en",   32'(bus.mem_wr_en_o),   32'(exp_v.wr));
            chk("reg_wr_en",   32'(bus.reg_wr_en_o),   32'(exp_v.reg_wr));
            chk("alu_src_a",   32'(bus.alu_src_a_o),   32'(exp_v.sa));
            chk("alu_src_b",   32'(bus.alu_src_b_o),   32'(exp_v.sb));
            chk("alu_op",      32'(bus.alu_op_o),      32'(exp_v.op));
            chk("result_src",  32'(bus.result_src_o),  32'(exp_v.res));
            chk("branch",      32'(bus.branch_o),      32'(exp_v.branch));
            chk("retire",      32'(bus.retire_o),      32'(exp_v.retire));
            chk("fault",       32'(bus.fault_o),       32'(exp_v.fault));
            chk("fault_cause", 32'(bus.fault_cause_o), 32'(exp_v.cause));
            chk("state",       32'(bus.state_o),       32'(exp_v.st));
            chk("retire_cnt",  32'(bus.retire_cnt_o),  32'(m_cnt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.opcode_i = 7'b0110011;
        bus.mem_ready_i = 1'b0;
        do_reset();

        run_instr(7'b0110011, 0, 0, 1'b0, 0);
        chk("cnt_after_add", 32'(bus.retire_cnt_o), 32'd1);

        // Asynchronous reset while a fetch request is outstanding.
        step(S_FETCH, 1'b0);
        step(S_FETCH, 1'b0);
        #2;
        rst_n = 1'b0;
        exp_v = '0;
        exp_v.st = S_FETCH;
        m_cause = 2'b00;
        m_cnt = '0;
        #1;
        chk("async_rst_mem_req", 32'(bus.mem_req_o), 32'd0);
        chk("async_rst_state",   32'(bus.state_o),   32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("cnt_after_rst", 32'(bus.retire_cnt_o), 32'd0);

        run_instr(7'b0000011, 3, 3, 1'b1, 0);
        chk("cnt_after_lw", 32'(bus.retire_cnt_o), 32'd1);
        run_instr(7'b0100011, 0, 1, 1'b0, 0);
        run_instr(7'b1100011, 1, 0, 1'b1, 0);
        chk("cnt_after_sw_beq", 32'(bus.retire_cnt_o), 32'd3);
        run_instr(7'b0010011, 1, 0, 1'b1, 0);
        run_instr(7'b1101111, 0, 0, 1'b0, 0);
        run_instr(7'b1100111, 2, 0, 1'b1, 0);
        run_instr(7'b0110111, 0, 0, 1'b0, 0);
        run_instr(7'b0010111, 0, 0, 1'b1, 0);
        run_instr(7'b0110011, TMO - 1, 0, 1'b0, 0);
        chk("limit_ready_no_fault", 32'(bus.fault_o), 32'd0);
        chk("cnt_before_wrap", 32'(bus.retire_cnt_o), 32'd9);
        for (int unsigned k = 0; k < 8; k++) run_instr(7'b0110011, k % 3, 0, k[0], 0);
        chk("cnt_wrapped", 32'(bus.retire_cnt_o), 32'd1);

        run_instr(7'b0110011, 100, 0, 1'b1, 6);
        chk("fetch_tmo_fault", 32'(bus.fault_o), 32'd1);
        chk("fetch_tmo_cause", 32'(bus.fault_cause_o), 32'd2);
        chk("fetch_tmo_cnt_frozen", 32'(bus.retire_cnt_o), 32'd1);
        do_reset();

        run_instr(7'b0000011, 0, 50, 1'b0, 3);
        chk("memrd_tmo_cause", 32'(bus.fault_cause_o), 32'd2);
        do_reset();

        run_instr(7'b0110011, 0, 0, 1'b0, 0);
        run_instr(7'b1111111, 0, 0, 1'b1, 20);
        chk("illegal_fault", 32'(bus.fault_o), 32'd1);
        chk("illegal_cause", 32'(bus.fault_cause_o), 32'd1);
        chk("illegal_cnt_frozen", 32'(bus.retire_cnt_o), 32'd1);
        chk("illegal_no_req", 32'(bus.mem_req_o), 32'd0);
        do_reset();

        run_instr(7'b0110011, 0, 0, 1'b0, 0);
        chk("recover_cnt", 32'(bus.retire_cnt_o), 32'd1);

        exp_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
